// File: rtl/fwd_source_tracker.sv
// fwd_source_tracker
// Tracks the destination register and write-back/load flags of the
// instructions sitting in ID/EX, EX/MEM and MEM/WB so the forwarding unit
// can compare sources against them. It also raises a load-use stall when
// the instruction in ID reads the destination of a load sitting in ID/EX.
//
// Optional feature: define FWD_STALL_COUNT_EN to add o_stall_count, a
// saturating count of enabled cycles spent stalled.
module fwd_source_tracker #(
  parameter int N_BITS_REG = 5,
  parameter int N_BITS_CNT = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [N_BITS_REG-1:0] i_rs_ID,
  input  logic [N_BITS_REG-1:0] i_rt_ID,
  input  logic [N_BITS_REG-1:0] i_rd_ID,
  input  logic                  i_regWrite_ID,
  input  logic                  i_memRead_ID,
  output logic [N_BITS_REG-1:0] o_rd_ID_EX,
  output logic                  o_regWrite_ID_EX,
  output logic                  o_memRead_ID_EX,
  output logic [N_BITS_REG-1:0] o_rd_EX_MEM,
  output logic                  o_regWrite_EX_MEM,
  output logic                  o_memRead_EX_MEM,
  output logic [N_BITS_REG-1:0] o_rd_MEM_WB,
  output logic                  o_regWrite_MEM_WB,
`ifdef FWD_STALL_COUNT_EN
  output logic [N_BITS_CNT-1:0] o_stall_count,
`endif
  output logic                  o_stall
);

  // Reject degenerate widths at elaboration time.
  if (N_BITS_REG < 1 || N_BITS_CNT < 1) begin : g_bad_width
    $error("fwd_source_tracker: widths must be at least 1");
  end

  // Stage registers: {rd, regWrite, memRead}; MEM/WB carries no load flag.
  logic [N_BITS_REG-1:0] rd_id_ex_q, rd_ex_mem_q, rd_mem_wb_q;
  logic                  rw_id_ex_q, rw_ex_mem_q, rw_mem_wb_q;
  logic                  mr_id_ex_q, mr_ex_mem_q;

  // Next value for ID/EX (the only stage that can take a bubble).
  logic [N_BITS_REG-1:0] rd_id_ex_d;
  logic                  rw_id_ex_d;
  logic                  mr_id_ex_d;

  logic                  stall_w;

  // Load-use hazard: a load to a non-zero register in ID/EX feeds a source in ID.
  always_comb begin
    stall_w = 1'b0;
    if (mr_id_ex_q && (rd_id_ex_q != '0) &&
        ((rd_id_ex_q == i_rs_ID) || (rd_id_ex_q == i_rt_ID))) begin
      stall_w = 1'b1;
    end
  end

  // Choose what enters ID/EX: a bubble on flush or stall (a single one if
  // both), otherwise the ID instruction with regWrite masked for register 0.
  always_comb begin
    rd_id_ex_d = i_rd_ID;
    rw_id_ex_d = i_regWrite_ID && (i_rd_ID != '0);
    mr_id_ex_d = i_memRead_ID;
    if (i_flush || stall_w) begin
      rd_id_ex_d = '0;
      rw_id_ex_d = 1'b0;
      mr_id_ex_d = 1'b0;
    end
  end

  // Advance the three stages on enabled edges; reset overrides everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_id_ex_q  <= '0;
      rw_id_ex_q  <= 1'b0;
      mr_id_ex_q  <= 1'b0;
      rd_ex_mem_q <= '0;
      rw_ex_mem_q <= 1'b0;
      mr_ex_mem_q <= 1'b0;
      rd_mem_wb_q <= '0;
      rw_mem_wb_q <= 1'b0;
    end else if (i_enable) begin
      rd_mem_wb_q <= rd_ex_mem_q;
      rw_mem_wb_q <= rw_ex_mem_q;
      rd_ex_mem_q <= rd_id_ex_q;
      rw_ex_mem_q <= rw_id_ex_q;
      mr_ex_mem_q <= mr_id_ex_q;
      rd_id_ex_q  <= rd_id_ex_d;
      rw_id_ex_q  <= rw_id_ex_d;
      mr_id_ex_q  <= mr_id_ex_d;
    end
  end

`ifdef FWD_STALL_COUNT_EN
  logic [N_BITS_CNT-1:0] stall_cnt_q;
  logic [N_BITS_CNT-1:0] stall_cnt_d;

  // Count stalled enabled cycles, sticking at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_enable && stall_w && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
`endif

  assign o_rd_ID_EX        = rd_id_ex_q;
  assign o_regWrite_ID_EX  = rw_id_ex_q;
  assign o_memRead_ID_EX   = mr_id_ex_q;
  assign o_rd_EX_MEM       = rd_ex_mem_q;
  assign o_regWrite_EX_MEM = rw_ex_mem_q;
  assign o_memRead_EX_MEM  = mr_ex_mem_q;
  assign o_rd_MEM_WB       = rd_mem_wb_q;
  assign o_regWrite_MEM_WB = rw_mem_wb_q;
  assign o_stall           = stall_w;

endmodule

// File: tb/tb_fwd_source_tracker.sv
// tb_fwd_source_tracker
// Directed vectors for fwd_source_tracker with hand-computed expectations.
// Define FWD_STALL_COUNT_EN to also check o_stall_count.
`timescale 1ns/1ps
module tb_fwd_source_tracker;

  localparam int NR = 5;
  localparam int NC = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic          flush;
  logic [NR-1:0] rs, rt, rd;
  logic          rw, mr;
  logic [NR-1:0] rd_ie, rd_em, rd_mw;
  logic          rw_ie, mr_ie, rw_em, mr_em, rw_mw;
  logic          stall;
`ifdef FWD_STALL_COUNT_EN
  logic [NC-1:0] stall_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  fwd_source_tracker #(.N_BITS_REG(NR), .N_BITS_CNT(NC)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_enable         (en),
    .i_flush          (flush),
    .i_rs_ID          (rs),
    .i_rt_ID          (rt),
    .i_rd_ID          (rd),
    .i_regWrite_ID    (rw),
    .i_memRead_ID     (mr),
    .o_rd_ID_EX       (rd_ie),
    .o_regWrite_ID_EX (rw_ie),
    .o_memRead_ID_EX  (mr_ie),
    .o_rd_EX_MEM      (rd_em),
    .o_regWrite_EX_MEM(rw_em),
    .o_memRead_EX_MEM (mr_em),
    .o_rd_MEM_WB      (rd_mw),
    .o_regWrite_MEM_WB(rw_mw),
`ifdef FWD_STALL_COUNT_EN
    .o_stall_count    (stall_count),
`endif
    .o_stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports a miscompare on one line.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every stage output and the stall flag.
  task automatic check_all(input string tag,
                           input int e_rd_ie, input int e_rw_ie, input int e_mr_ie,
                           input int e_rd_em, input int e_rw_em, input int e_mr_em,
                           input int e_rd_mw, input int e_rw_mw, input int e_stall);
    check({tag, ".rd_ID_EX"},  32'(rd_ie), e_rd_ie);
    check({tag, ".rw_ID_EX"},  32'(rw_ie), e_rw_ie);
    check({tag, ".mr_ID_EX"},  32'(mr_ie), e_mr_ie);
    check({tag, ".rd_EX_MEM"}, 32'(rd_em), e_rd_em);
    check({tag, ".rw_EX_MEM"}, 32'(rw_em), e_rw_em);
    check({tag, ".mr_EX_MEM"}, 32'(mr_em), e_mr_em);
    check({tag, ".rd_MEM_WB"}, 32'(rd_mw), e_rd_mw);
    check({tag, ".rw_MEM_WB"}, 32'(rw_mw), e_rw_mw);
    check({tag, ".stall"},     32'(stall), e_stall);
    $display("vec %-10s ie=%0d/%0d/%0d em=%0d/%0d/%0d mw=%0d/%0d stall=%0d",
             tag, rd_ie, rw_ie, mr_ie, rd_em, rw_em, mr_em, rd_mw, rw_mw, stall);
  endtask

  task automatic check_cnt(input string tag, input int e_cnt);
`ifdef FWD_STALL_COUNT_EN
    check({tag, ".count"}, 32'(stall_count), e_cnt);
`else
    if (e_cnt < 0) $display("unused %s", tag);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int a_rs, input int a_rt, input int a_rd, input bit a_rw, input bit a_mr);
    rs = NR'(a_rs);
    rt = NR'(a_rt);
    rd = NR'(a_rd);
    rw = a_rw;
    mr = a_mr;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b1;
    set_id(1, 2, 3, 1'b1, 1'b1);
    #2;
    // Reset wins over enable=0 and flush=1.
    step();
    rst = 1'b0; flush = 1'b0;
    set_id(1, 2, 0, 1'b0, 1'b0);
    #1;
    check_all("reset", 0,0,0, 0,0,0, 0,0, 0);
    check_cnt("reset", 0);

    // Latency through the three stages.
    en = 1'b1;
    set_id(1, 2, 3, 1'b1, 1'b0);
    step(); check_all("lat1", 3,1,0, 0,0,0, 0,0, 0);
    set_id(1, 2, 4, 1'b0, 1'b0);
    step(); check_all("lat2", 4,0,0, 3,1,0, 0,0, 0);
    set_id(1, 2, 6, 1'b1, 1'b0);
    step(); check_all("lat3", 6,1,0, 4,0,0, 3,1, 0);

    // Load-use: load r5, then a reader of r5.
    set_id(1, 2, 5, 1'b1, 1'b1);
    step(); check_all("load", 5,1,1, 6,1,0, 4,0, 0);
    set_id(5, 9, 8, 1'b1, 1'b0);
    #1; check("lu.stall_on", 32'(stall), 1);
    step(); check_all("lu.bubble", 0,0,0, 5,1,1, 6,1, 0);
    check_cnt("lu", 1);
    step(); check_all("lu.resume", 8,1,0, 0,0,0, 5,1, 0);

    // Register zero: load to r0 never stalls and never writes back.
    set_id(0, 0, 0, 1'b1, 1'b1);
    step(); check_all("r0", 0,0,1, 8,1,0, 0,0, 0);

    // Flush replaces the ID instruction; older stages advance untouched.
    set_id(1, 2, 10, 1'b1, 1'b0);
    step(); check_all("pre_flush", 10,1,0, 0,0,1, 8,1, 0);
    flush = 1'b1;
    set_id(1, 2, 7, 1'b1, 1'b0);
    step(); check_all("flush", 0,0,0, 10,1,0, 0,0, 0);
    flush = 1'b0;

    // Hold for 4 cycles during a hazard.
    set_id(1, 2, 12, 1'b1, 1'b1);
    step(); check_all("load12", 12,1,1, 0,0,0, 10,1, 0);
    set_id(3, 12, 13, 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); check_all("hold", 12,1,1, 0,0,0, 10,1, 1);
      check_cnt("hold", 1);
    end

    // Flush and stall together: exactly one bubble.
    en = 1'b1; flush = 1'b1;
    step(); check_all("fl+st", 0,0,0, 12,1,1, 0,0, 0);
    check_cnt("fl+st", 2);
    flush = 1'b0;

    // Reset while stalled clears everything.
    set_id(1, 2, 14, 1'b1, 1'b1);
    step(); check_all("load14", 14,1,1, 0,0,0, 12,1, 0);
    set_id(14, 2, 15, 1'b1, 1'b0);
    #1; check("rst_st.stall_on", 32'(stall), 1);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    check_all("rst_stall", 0,0,0, 0,0,0, 0,0, 0);
    check_cnt("rst_stall", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Bound the run in case something hangs.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fwd_source_tracker.md
FWD_SOURCE_TRACKER -- requirements
Module: fwd_source_tracker

Interface
REQ-001 Parameter N_BITS_REG, default 5, SHALL set the register-index width.
REQ-002 Parameter N_BITS_CNT, default 16, SHALL set the stall-counter width (used only under REQ-026).
REQ-003 i_clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 i_enable  in  1  SHALL be the pipeline advance enable; 0 means hold all state (debug step mode).
REQ-006 i_flush  in  1  SHALL request that the instruction entering ID/EX be replaced by a bubble.
REQ-007 i_rs_ID, i_rt_ID  in  N_BITS_REG  SHALL be the source registers of the instruction in ID.
REQ-008 i_rd_ID  in  N_BITS_REG  SHALL be the destination register of the instruction in ID.
REQ-009 i_regWrite_ID, i_memRead_ID  in  1  SHALL be that instruction's write-back and load flags.
REQ-010 o_rd_ID_EX, o_regWrite_ID_EX, o_memRead_ID_EX  out  N_BITS_REG/1/1  SHALL be the ID/EX stage destination state.
REQ-011 o_rd_EX_MEM, o_regWrite_EX_MEM, o_memRead_EX_MEM  out  N_BITS_REG/1/1  SHALL be the EX/MEM stage destination state; they drive the forwarding unit.
REQ-012 o_rd_MEM_WB, o_regWrite_MEM_WB  out  N_BITS_REG/1  SHALL be the MEM/WB stage destination state; they drive the forwarding unit.
REQ-013 o_stall  out  1  SHALL request that PC and IF/ID be held (load-use hazard).

Function
REQ-014 Each stage register SHALL hold {rd, regWrite, memRead}; a bubble is {0,0,0}.
REQ-015 o_stall SHALL be combinational: 1 iff o_memRead_ID_EX=1, o_rd_ID_EX!=0, and o_rd_ID_EX equals i_rs_ID or i_rt_ID.
REQ-016 On an edge with i_enable=1: MEM/WB <= EX/MEM; EX/MEM <= ID/EX; ID/EX <= next value per REQ-017 to REQ-018.
REQ-017 ID/EX next value SHALL be a bubble if i_flush=1 or o_stall=1; otherwise it SHALL be the ID inputs.
REQ-018 When capturing the ID inputs with i_rd_ID=0, regWrite SHALL be captured as 0 (register zero never forwards).
REQ-019 With i_enable=0, all stage registers SHALL hold and o_stall SHALL still be evaluated from the held state.
REQ-020 Latency: an ID instruction SHALL appear at ID/EX after 1 enabled edge, EX/MEM after 2, and MEM/WB after 3.
REQ-021 A load-use stall SHALL last exactly one enabled cycle: the bubble enters ID/EX, the load moves to EX/MEM, and o_stall drops.
REQ-022 Simultaneous i_flush and o_stall SHALL produce a single bubble; there is no double insertion.
REQ-023 Stages already past ID/EX SHALL never be modified by i_flush or o_stall.

Reset
REQ-024 With i_reset=1 at an edge, all three stages SHALL become bubbles regardless of i_enable or i_flush, giving all outputs 0, o_stall=0.
REQ-025 Reset mid-stall SHALL clear the stall; the first post-reset cycle SHALL show o_stall=0.

Configuration
REQ-026 Macro FWD_STALL_COUNT_EN: when defined, output o_stall_count (N_BITS_CNT) SHALL increment on each enabled edge where o_stall=1, saturate at all-ones, and reset to 0; when undefined, the port and logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-027 Reset then ID {rd=3, regWrite=1} for 3 enabled edges -> rd 3 at ID/EX, then EX/MEM, then MEM/WB on edges 1/2/3, regWrite=1 each; o_stall=0.
REQ-028 Load {rd=5, memRead=1} in ID/EX with next i_rs_ID=5 -> o_stall=1; after 1 edge ID/EX is a bubble, o_memRead_EX_MEM=1 with rd=5, and o_stall=0.
REQ-029 Load rd=0 in ID/EX with i_rt_ID=0 -> o_stall=0; ID instruction with rd=0 and regWrite=1 -> o_regWrite_ID_EX=0.
REQ-030 i_flush=1 with valid ID {rd=7} -> ID/EX becomes a bubble; the prior ID/EX contents advance to EX/MEM unchanged.
REQ-031 i_enable=0 for 4 cycles during a load-use hazard -> all outputs hold and o_stall stays 1; with FWD_STALL_COUNT_EN, o_stall_count is unchanged.
REQ-032 i_reset=1 while the pipeline is full and stalled -> next cycle all outputs are 0 and o_stall=0.
